// File: rtl/scratch_pad_bank.sv
// scratch_pad_bank: NUM_REGS scratch registers behind the OPB register slave.
// Adds byte-enabled writes, a write lock, access-error reporting, a registered
// read-valid strobe and a saturating count of accepted writes.
//
// Access protocol: SP_WE and SP_RE are single-cycle strobes sampled on the
// rising edge of OPB_CLK. Every strobe is consumed at that edge; there is no
// ready/back-pressure, so one access per cycle is always accepted. SP_RVALID
// pulses for exactly one cycle after each read edge and qualifies SP_DO.
// SP_ERR pulses for one cycle after an edge at which any access was rejected.
module scratch_pad_bank #(
  parameter int          DATA_W     = 32,
  parameter int          NUM_REGS   = 8,
  parameter int          ADDR_W     = 3,
  parameter logic [31:0] RESET_BASE = 32'h12345678,
  parameter logic [31:0] RESET_STEP = 32'h11111111,
  parameter int          CNT_W      = 16
) (
  input  logic                OPB_CLK,
  input  logic                OPB_RST_N,
  input  logic [ADDR_W-1:0]   SP_ADDR,
  input  logic [DATA_W-1:0]   SP_DI,
  input  logic [DATA_W/8-1:0] SP_BE,
  input  logic                SP_WE,
  input  logic                SP_RE,
  input  logic                SP_LOCK,
  output logic [DATA_W-1:0]   SP_DO,
  output logic                SP_RVALID,
  output logic                SP_ERR,
  output logic [CNT_W-1:0]    SP_WR_CNT
);

  localparam int NUM_BYTES = DATA_W / 8;

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] rd_data;
  logic              addr_ok;
  logic              wr_ok;

  // Reset value of register idx; arithmetic wraps modulo 2**DATA_W.
  function automatic logic [DATA_W-1:0] reset_value(input int idx);
    return DATA_W'(RESET_BASE) + DATA_W'(idx) * DATA_W'(RESET_STEP);
  endfunction

  // Addresses at or beyond NUM_REGS are never aliased onto real registers.
  assign addr_ok = (32'(SP_ADDR) < NUM_REGS);
  assign wr_ok   = SP_WE && addr_ok && !SP_LOCK;

  // Read mux by explicit compare so unused address codes select nothing.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (SP_ADDR == ADDR_W'(i)) rd_data = regs[i];
    end
  end

  // Register array: byte-enabled update on accepted writes only.
  always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
    if (!OPB_RST_N) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= reset_value(i);
    end else if (wr_ok) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (SP_ADDR == ADDR_W'(i)) begin
          for (int b = 0; b < NUM_BYTES; b++) begin
            if (SP_BE[b]) regs[i][8*b +: 8] <= SP_DI[8*b +: 8];
          end
        end
      end
    end
  end

  // Read port: samples the pre-write contents, so WE+RE returns the old value.
  always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
    if (!OPB_RST_N) begin
      SP_DO     <= '0;
      SP_RVALID <= 1'b0;
    end else begin
      SP_RVALID <= SP_RE;
      if (SP_RE) SP_DO <= addr_ok ? rd_data : '0;
    end
  end

  // Error strobe: one pulse even when both the read and the write are rejected.
  always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
    if (!OPB_RST_N) SP_ERR <= 1'b0;
    else            SP_ERR <= (SP_WE && !wr_ok) || (SP_RE && !addr_ok);
  end

  // Accepted-write counter, including writes with no byte enabled; saturates.
  always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
    if (!OPB_RST_N)                     SP_WR_CNT <= '0;
    else if (wr_ok && SP_WR_CNT != '1)  SP_WR_CNT <= SP_WR_CNT + CNT_W'(1);
  end

endmodule

// File: tb/tb_scratch_pad_bank.sv
// tb_scratch_pad_bank: directed vectors against two configurations sharing one
// stimulus bus: dut_a (defaults) and dut_b (NUM_REGS = 6, CNT_W = 4).
module tb_scratch_pad_bank;

  logic        OPB_CLK;
  logic        OPB_RST_N;
  logic [2:0]  SP_ADDR;
  logic [31:0] SP_DI;
  logic [3:0]  SP_BE;
  logic        SP_WE;
  logic        SP_RE;
  logic        SP_LOCK;

  logic [31:0] do_a, do_b;
  logic        rv_a, rv_b, err_a, err_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;

  int n_checks = 0;
  int n_fail   = 0;

  scratch_pad_bank dut_a (
    .OPB_CLK(OPB_CLK), .OPB_RST_N(OPB_RST_N), .SP_ADDR(SP_ADDR), .SP_DI(SP_DI),
    .SP_BE(SP_BE), .SP_WE(SP_WE), .SP_RE(SP_RE), .SP_LOCK(SP_LOCK),
    .SP_DO(do_a), .SP_RVALID(rv_a), .SP_ERR(err_a), .SP_WR_CNT(cnt_a)
  );

  scratch_pad_bank #(.NUM_REGS(6), .CNT_W(4)) dut_b (
    .OPB_CLK(OPB_CLK), .OPB_RST_N(OPB_RST_N), .SP_ADDR(SP_ADDR), .SP_DI(SP_DI),
    .SP_BE(SP_BE), .SP_WE(SP_WE), .SP_RE(SP_RE), .SP_LOCK(SP_LOCK),
    .SP_DO(do_b), .SP_RVALID(rv_b), .SP_ERR(err_b), .SP_WR_CNT(cnt_b)
  );

  // Clock and reset
  initial begin
    OPB_CLK = 1'b0;
    forever #5 OPB_CLK = ~OPB_CLK;
  end

  typedef struct {
    logic        sel;      // 0: check dut_a, 1: check dut_b
    logic        we;
    logic        re;
    logic        lock;
    logic [2:0]  addr;
    logic [31:0] di;
    logic [3:0]  be;
    logic        exp_rv;
    logic [31:0] exp_do;
    logic        exp_err;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs_a[$];
  vec_t vecs_b[$];

  function automatic vec_t mk(logic sel, logic we, logic re, logic lock, logic [2:0] addr,
                              logic [31:0] di, logic [3:0] be, logic exp_rv,
                              logic [31:0] exp_do, logic exp_err, logic [15:0] exp_cnt);
    vec_t v;
    v.sel = sel; v.we = we; v.re = re; v.lock = lock; v.addr = addr; v.di = di; v.be = be;
    v.exp_rv = exp_rv; v.exp_do = exp_do; v.exp_err = exp_err; v.exp_cnt = exp_cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Driver: present one access at the falling edge, let the rising edge take it.
  task automatic drive(input logic we, input logic re, input logic lock, input logic [2:0] addr,
                       input logic [31:0] di, input logic [3:0] be);
    @(negedge OPB_CLK);
    SP_WE = we; SP_RE = re; SP_LOCK = lock; SP_ADDR = addr; SP_DI = di; SP_BE = be;
    @(posedge OPB_CLK);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    drive(v.we, v.re, v.lock, v.addr, v.di, v.be);
    tag = $sformatf("vec%0d_%s", idx, v.sel ? "b" : "a");
    if (!v.sel) begin
      check({tag, "_rvalid"}, 32'(rv_a),  32'(v.exp_rv));
      check({tag, "_do"},     do_a,       v.exp_do);
      check({tag, "_err"},    32'(err_a), 32'(v.exp_err));
      check({tag, "_cnt"},    32'(cnt_a), 32'(v.exp_cnt));
    end else begin
      check({tag, "_rvalid"}, 32'(rv_b),  32'(v.exp_rv));
      check({tag, "_do"},     do_b,       v.exp_do);
      check({tag, "_err"},    32'(err_b), 32'(v.exp_err));
      check({tag, "_cnt"},    32'(cnt_b), 32'(v.exp_cnt));
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_do_a"},  do_a,        32'h0);
    check({name, "_rv_a"},  32'(rv_a),   32'h0);
    check({name, "_err_a"}, 32'(err_a),  32'h0);
    check({name, "_cnt_a"}, 32'(cnt_a),  32'h0);
    check({name, "_do_b"},  do_b,        32'h0);
    check({name, "_rv_b"},  32'(rv_b),   32'h0);
    check({name, "_err_b"}, 32'(err_b),  32'h0);
    check({name, "_cnt_b"}, 32'(cnt_b),  32'h0);
  endtask

  task automatic do_reset();
    @(negedge OPB_CLK);
    OPB_RST_N = 1'b0;
    SP_WE = 0; SP_RE = 0; SP_LOCK = 0; SP_ADDR = '0; SP_DI = '0; SP_BE = '0;
    @(negedge OPB_CLK);
    @(negedge OPB_CLK);
    OPB_RST_N = 1'b1;
  endtask

  logic [31:0] defaults [8];

  initial begin
    OPB_RST_N = 1'b0;
    SP_WE = 0; SP_RE = 0; SP_LOCK = 0; SP_ADDR = '0; SP_DI = '0; SP_BE = '0;

    defaults[0] = 32'h12345678; defaults[1] = 32'h23456789;
    defaults[2] = 32'h3456789A; defaults[3] = 32'h456789AB;
    defaults[4] = 32'h56789ABC; defaults[5] = 32'h6789ABCD;
    defaults[6] = 32'h789ABCDE; defaults[7] = 32'h89ABCDEF;

    // Default configuration: defaults, byte enables, lock, read-before-write.
    for (int i = 0; i < 8; i++)
      vecs_a.push_back(mk(0, 0, 1, 0, 3'(i), 32'h0, 4'h0, 1, defaults[i], 0, 16'd0));
    vecs_a.push_back(mk(0, 0, 0, 0, 3'd0, 32'h0,        4'h0, 0, 32'h89ABCDEF, 0, 16'd0));
    vecs_a.push_back(mk(0, 1, 0, 0, 3'd3, 32'hDEADBEEF, 4'h5, 0, 32'h89ABCDEF, 0, 16'd1));
    vecs_a.push_back(mk(0, 0, 1, 0, 3'd3, 32'h0,        4'h0, 1, 32'h45AD89EF, 0, 16'd1));
    vecs_a.push_back(mk(0, 1, 0, 1, 3'd1, 32'hFFFFFFFF, 4'hF, 0, 32'h45AD89EF, 1, 16'd1));
    vecs_a.push_back(mk(0, 0, 1, 1, 3'd1, 32'h0,        4'h0, 1, 32'h23456789, 0, 16'd1));
    vecs_a.push_back(mk(0, 1, 0, 0, 3'd1, 32'hFFFFFFFF, 4'hF, 0, 32'h23456789, 0, 16'd2));
    vecs_a.push_back(mk(0, 0, 1, 0, 3'd1, 32'h0,        4'h0, 1, 32'hFFFFFFFF, 0, 16'd2));
    vecs_a.push_back(mk(0, 1, 1, 0, 3'd5, 32'hCAFEF00D, 4'hF, 1, 32'h6789ABCD, 0, 16'd3));
    vecs_a.push_back(mk(0, 0, 1, 0, 3'd5, 32'h0,        4'h0, 1, 32'hCAFEF00D, 0, 16'd3));
    vecs_a.push_back(mk(0, 1, 0, 0, 3'd0, 32'hFFFFFFFF, 4'h0, 0, 32'hCAFEF00D, 0, 16'd4));
    vecs_a.push_back(mk(0, 0, 1, 0, 3'd0, 32'h0,        4'h0, 1, 32'h12345678, 0, 16'd4));

    // NUM_REGS = 6 configuration: range errors and no aliasing.
    vecs_b.push_back(mk(1, 0, 1, 0, 3'd5, 32'h0,        4'h0, 1, 32'h6789ABCD, 0, 16'd0));
    vecs_b.push_back(mk(1, 0, 1, 0, 3'd7, 32'h0,        4'h0, 1, 32'h00000000, 1, 16'd0));
    vecs_b.push_back(mk(1, 1, 0, 0, 3'd6, 32'hFFFFFFFF, 4'hF, 0, 32'h00000000, 1, 16'd0));
    vecs_b.push_back(mk(1, 0, 1, 0, 3'd0, 32'h0,        4'h0, 1, 32'h12345678, 0, 16'd0));
    vecs_b.push_back(mk(1, 0, 1, 0, 3'd2, 32'h0,        4'h0, 1, 32'h3456789A, 0, 16'd0));
    vecs_b.push_back(mk(1, 0, 1, 0, 3'd6, 32'h0,        4'h0, 1, 32'h00000000, 1, 16'd0));
    vecs_b.push_back(mk(1, 1, 1, 0, 3'd7, 32'h55555555, 4'hF, 1, 32'h00000000, 1, 16'd0));
    vecs_b.push_back(mk(1, 0, 0, 0, 3'd0, 32'h0,        4'h0, 0, 32'h00000000, 0, 16'd0));
    vecs_b.push_back(mk(1, 1, 0, 0, 3'd5, 32'h00000001, 4'hF, 0, 32'h00000000, 0, 16'd1));
    vecs_b.push_back(mk(1, 0, 1, 0, 3'd5, 32'h0,        4'h0, 1, 32'h00000001, 0, 16'd1));

    // Reset state, sampled while reset is still asserted.
    @(negedge OPB_CLK);
    @(negedge OPB_CLK);
    check_all_zero("reset");
    OPB_RST_N = 1'b1;

    foreach (vecs_a[i]) run_vec(vecs_a[i], i);

    do_reset();
    foreach (vecs_b[i]) run_vec(vecs_b[i], i);

    // Saturation: 19 more accepted writes on dut_b bring the total to 20.
    for (int k = 0; k < 19; k++) begin
      int exp_cnt;
      drive(1, 0, 0, 3'd1, 32'hA0000000 + 32'(k), 4'hF);
      exp_cnt = (k + 2 > 15) ? 15 : k + 2;
      check($sformatf("sat_cnt_%0d", k), 32'(cnt_b), 32'(exp_cnt));
    end
    drive(0, 1, 0, 3'd1, 32'h0, 4'h0);
    check("sat_last_data", do_b, 32'hA0000012);
    check("sat_final_cnt", 32'(cnt_b), 32'd15);
    check("sat_rvalid",    32'(rv_b), 32'd1);

    // Asynchronous reset in the middle of a read burst.
    @(negedge OPB_CLK);
    SP_RE = 1'b1; SP_ADDR = 3'd1;
    @(posedge OPB_CLK);
    #2;
    OPB_RST_N = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(posedge OPB_CLK);
    #1;
    check("rst_hold_rv_b", 32'(rv_b), 32'd0);
    @(negedge OPB_CLK);
    SP_RE = 1'b0;
    OPB_RST_N = 1'b1;
    @(posedge OPB_CLK);
    #1;
    check_all_zero("post_release");
    drive(0, 1, 0, 3'd1, 32'h0, 4'h0);
    check("rst_default_b1", do_b, 32'h23456789);
    check("rst_default_a1", do_a, 32'h23456789);
    drive(0, 1, 0, 3'd5, 32'h0, 4'h0);
    check("rst_default_b5", do_b, 32'h6789ABCD);
    check("rst_cnt_b",      32'(cnt_b), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/scratch_pad_bank.md
Name: scratch_pad_bank

Overview:
Parametrised bank of NUM_REGS read/write scratch-pad registers on the OPB register slave. It replaces the fixed two-register scratch pad. Software uses it for bus sanity checks and persistent scratch storage. Added over the fixed version: address decode, byte enables, write lock, access-error reporting, a registered read-valid strobe and a saturating write counter.

Parameters:
DATA_W, 32, register width in bits; must be a multiple of 8, minimum 8
NUM_REGS, 8, number of scratch registers, 1..2**ADDR_W
ADDR_W, 3, width of SP_ADDR
RESET_BASE, 32'h12345678, reset value of register 0 (truncated to DATA_W)
RESET_STEP, 32'h11111111, increment between reset values of consecutive registers
CNT_W, 16, width of write counter

Ports:
OPB_CLK  in  1  clock
OPB_RST_N  in  1  asynchronous active-low reset
SP_ADDR  in  ADDR_W  register index for the current access
SP_DI  in  DATA_W  write data
SP_BE  in  DATA_W/8  byte enables for write, bit k covers bits [8k+7:8k]
SP_WE  in  1  write strobe, one access per cycle
SP_RE  in  1  read strobe, one access per cycle
SP_LOCK  in  1  level; when high all writes are rejected
SP_DO  out  DATA_W  registered read data
SP_RVALID  out  1  one-cycle pulse, SP_DO updated this cycle
SP_ERR  out  1  one-cycle pulse, the access in the previous cycle was rejected
SP_WR_CNT  out  CNT_W  count of accepted writes, saturating

Behaviour:
- Reset (OPB_RST_N low, async assert, released on clock edge):
  - reg[i] = (RESET_BASE + i*RESET_STEP) mod 2**DATA_W.
  - SP_DO = 0, SP_RVALID = 0, SP_ERR = 0, SP_WR_CNT = 0.
  - An in-flight access is discarded; no RVALID or ERR pulse follows reset release.
- Write: sampled on the rising edge with SP_WE = 1.
  - Accepted when SP_ADDR < NUM_REGS and SP_LOCK = 0.
  - On acceptance, only bytes with SP_BE[k] = 1 update; the other bytes hold.
  - Any accepted write increments SP_WR_CNT by 1, including SP_BE = 0. Saturates at 2**CNT_W-1, no wrap.
- Write rejection: SP_ADDR >= NUM_REGS or SP_LOCK = 1.
  - No register changes, counter unchanged.
  - SP_ERR = 1 in the next cycle.
- Read: SP_RE = 1 at edge N; SP_DO and SP_RVALID = 1 are valid after edge N (latency 1).
  - SP_RVALID lasts exactly one cycle per read.
  - SP_DO holds its last value when no read is issued.
  - SP_LOCK does not affect reads.
- Read out of range: SP_DO = 0, SP_RVALID = 1, SP_ERR = 1 in the same cycle.
- SP_WE and SP_RE together, same address: read returns the pre-write value (read-before-write). The write still takes effect at the same edge. A read in the following cycle returns the new value.
- SP_WE and SP_RE together, both rejected: a single SP_ERR pulse.
- Back-to-back accesses: one per cycle, no stall, no handshake back-pressure.
- Unused address space: decoded as out of range, never aliased.
- NUM_REGS = 2**ADDR_W: every address is valid; the range error is never raised.

Test Plan:
- Reset, then read addr 0..7 with defaults -> SP_DO = 12345678, 23456789, 3456789A, 456789AB, 56789ABC, 6789ABCD, 789ABCDE, 89ABCDEF; RVALID pulses one cycle after each RE.
- Write addr 3, SP_DI = DEADBEEF, SP_BE = 0101, then read 3 -> 45AD89EF; SP_WR_CNT = 1.
- SP_LOCK = 1, write addr 1 = FFFFFFFF -> SP_ERR pulse, read 1 still 23456789, counter unchanged. Release lock, repeat write -> read FFFFFFFF.
- Same-cycle WE+RE addr 5, data CAFEF00D -> SP_DO = 6789ABCD. Next read -> CAFEF00D.
- NUM_REGS = 6: read addr 7 -> SP_DO = 0, RVALID = 1, ERR = 1. Write addr 6 -> ERR, no register change.
- CNT_W = 4: 20 accepted writes -> SP_WR_CNT = 15. Assert OPB_RST_N low mid-burst with RE high -> all outputs 0 immediately, registers at defaults, no RVALID after release.
